// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard.
// Entry layout, stage indices and forwarding-select encoding.
package hazard_scoreboard_pkg;

    // Widest register address an entry can hold; narrower addresses zero-extend.
    localparam int SB_RD_W = 8;

    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic               v;
        logic [SB_RD_W-1:0] rd;
        logic               we;
        logic               ld;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-side bundle of the hazard scoreboard.
// master drives the decoded instruction, slave returns stall/forwarding.
interface hazard_scoreboard_if #(
    parameter int NB_REG_ADDR = 5,
    parameter int NB_FWD      = 2,
    parameter int NB_CNT      = 16
);
    logic                   i_valid;
    logic                   i_id_valid;
    logic                   i_flush;
    logic [NB_REG_ADDR-1:0] i_rs;
    logic [NB_REG_ADDR-1:0] i_rt;
    logic                   i_use_rs;
    logic                   i_use_rt;
    logic                   i_jmp_branch;
    logic [NB_REG_ADDR-1:0] i_rd;
    logic                   i_rd_we;
    logic                   i_re;
    logic                   o_hazard;
    logic [NB_FWD-1:0]      o_fwd_rs;
    logic [NB_FWD-1:0]      o_fwd_rt;
    logic [NB_CNT-1:0]      o_stall_cycles;

    modport master (
        output i_valid, i_id_valid, i_flush, i_rs, i_rt,
        output i_use_rs, i_use_rt, i_jmp_branch, i_rd, i_rd_we, i_re,
        input  o_hazard, o_fwd_rs, o_fwd_rt, o_stall_cycles
    );

    modport slave (
        input  i_valid, i_id_valid, i_flush, i_rs, i_rt,
        input  i_use_rs, i_use_rt, i_jmp_branch, i_rd, i_rd_we, i_re,
        output o_hazard, o_fwd_rs, o_fwd_rt, o_stall_cycles
    );

endinterface

// File: rtl/hazard_scoreboard_stage_match.sv
// Compares one in-flight entry against the ID source operands.
// "late" means the entry's result is not yet available to the consumer.
module hazard_stage_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int STAGE      = STG_EX,
    parameter int N_STAGES   = 3,
    parameter int LOAD_READY = STG_MEM,
    parameter int ALU_READY  = STG_EX
) (
    input  sb_entry_t          i_entry,
    input  logic [SB_RD_W-1:0] i_rs,
    input  logic [SB_RD_W-1:0] i_rt,
    input  logic               i_jmp_branch,
    output logic               o_hit_rs,
    output logic               o_hit_rt,
    output logic               o_late_rs,
    output logic               o_late_rt
);
    // The last stage writes the register file before ID reads it.
    localparam bit IS_WB = (STAGE == N_STAGES - 1);

    localparam bit LD_LATE_EX  = !IS_WB && (STAGE <  LOAD_READY);
    localparam bit LD_LATE_ID  = !IS_WB && (STAGE <= LOAD_READY);
    localparam bit ALU_LATE_EX = !IS_WB && (STAGE <  ALU_READY);
    localparam bit ALU_LATE_ID = !IS_WB && (STAGE <= ALU_READY);

    logic late;

    // Address match per operand, then whether the result is still in flight.
    always_comb begin
        o_hit_rs = i_entry.v & i_entry.we & (i_entry.rd == i_rs) & (i_rs != '0);
        o_hit_rt = i_entry.v & i_entry.we & (i_entry.rd == i_rt) & (i_rt != '0);
        case ({i_jmp_branch, i_entry.ld})
            2'b00:   late = ALU_LATE_EX;
            2'b01:   late = LD_LATE_EX;
            2'b10:   late = ALU_LATE_ID;
            default: late = LD_LATE_ID;
        endcase
        o_late_rs = o_hit_rs & late;
        o_late_rt = o_hit_rt & late;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard detector beside the ID stage.
// Tracks in-flight destinations, stalls, selects forwarding, counts stalls.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NB_REG_ADDR = 5,
    parameter int N_STAGES    = 3,
    parameter int LOAD_READY  = STG_MEM,
    parameter int ALU_READY   = STG_EX,
    parameter int NB_FWD      = 2,
    parameter int NB_CNT      = 16
) (
    input logic                i_clock,
    input logic                i_reset,
    hazard_scoreboard_if.slave sb
);
    sb_entry_t [N_STAGES-1:0] sb_q, sb_d;
    logic [NB_CNT-1:0]        cnt_q, cnt_d;

    logic [N_STAGES-1:0] hit_rs, hit_rt, late_rs, late_rt;
    logic [SB_RD_W-1:0]  rs_w, rt_w;
    logic                hazard, push;
    logic [NB_FWD-1:0]   fwd_rs, fwd_rt;

    assign rs_w = SB_RD_W'(sb.i_rs);
    assign rt_w = SB_RD_W'(sb.i_rt);

    for (genvar g = 0; g < N_STAGES; g++) begin : g_match
        hazard_stage_match #(
            .STAGE      (g),
            .N_STAGES   (N_STAGES),
            .LOAD_READY (LOAD_READY),
            .ALU_READY  (ALU_READY)
        ) u_match (
            .i_entry      (sb_q[g]),
            .i_rs         (rs_w),
            .i_rt         (rt_w),
            .i_jmp_branch (sb.i_jmp_branch),
            .o_hit_rs     (hit_rs[g]),
            .o_hit_rt     (hit_rt[g]),
            .o_late_rs    (late_rs[g]),
            .o_late_rt    (late_rt[g])
        );
    end

    // Stall when a used operand is still in flight; a flush cancels it.
    always_comb begin
        hazard = sb.i_id_valid & ~sb.i_flush &
                 ((sb.i_use_rs & |late_rs) | (sb.i_use_rt & |late_rt));
        push   = sb.i_id_valid & ~sb.i_flush & ~hazard;
    end

    // Youngest ready match wins: scan oldest to youngest, last hit sticks.
    always_comb begin
        fwd_rs = NB_FWD'(FWD_REGFILE);
        fwd_rt = NB_FWD'(FWD_REGFILE);
        for (int k = N_STAGES - 1; k >= 0; k--) begin
            if (hit_rs[k] && !late_rs[k]) fwd_rs = NB_FWD'(k + 1);
            if (hit_rt[k] && !late_rt[k]) fwd_rt = NB_FWD'(k + 1);
        end
    end

    // Advance the scoreboard and stall counter when the pipeline moves.
    always_comb begin
        sb_d  = sb_q;
        cnt_d = cnt_q;
        if (sb.i_valid) begin
            for (int s = N_STAGES - 1; s > 0; s--) begin
                sb_d[s] = sb_q[s-1];
            end
            sb_d[0] = '0;
            if (push) begin
                sb_d[0].v  = 1'b1;
                sb_d[0].rd = SB_RD_W'(sb.i_rd);
                sb_d[0].we = sb.i_rd_we;
                sb_d[0].ld = sb.i_re;
            end
            if (hazard && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
        end
    end

    assign sb.o_hazard       = hazard;
    assign sb.o_fwd_rs       = fwd_rs;
    assign sb.o_fwd_rt       = fwd_rt;
    assign sb.o_stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed instruction streams against
// an in-flight-instruction model; a 3-bit-counter copy exercises saturation.
module tb_hazard_scoreboard;

    localparam int N  = 3;
    localparam int LR = 1;
    localparam int AR = 0;

    logic clk, rst_n;
    logic valid, idv, flush, urs, urt, jb, we, re;
    logic [4:0] rs, rt, rd;

    int n_checks = 0;
    int n_errors = 0;

    hazard_scoreboard_if #(.NB_REG_ADDR(5), .NB_FWD(2), .NB_CNT(16)) ifa ();
    hazard_scoreboard_if #(.NB_REG_ADDR(5), .NB_FWD(2), .NB_CNT(3))  ifb ();

    assign ifa.i_valid = valid;      assign ifb.i_valid = valid;
    assign ifa.i_id_valid = idv;     assign ifb.i_id_valid = idv;
    assign ifa.i_flush = flush;      assign ifb.i_flush = flush;
    assign ifa.i_rs = rs;            assign ifb.i_rs = rs;
    assign ifa.i_rt = rt;            assign ifb.i_rt = rt;
    assign ifa.i_use_rs = urs;       assign ifb.i_use_rs = urs;
    assign ifa.i_use_rt = urt;       assign ifb.i_use_rt = urt;
    assign ifa.i_jmp_branch = jb;    assign ifb.i_jmp_branch = jb;
    assign ifa.i_rd = rd;            assign ifb.i_rd = rd;
    assign ifa.i_rd_we = we;         assign ifb.i_rd_we = we;
    assign ifa.i_re = re;            assign ifb.i_re = re;

    hazard_scoreboard #(.NB_CNT(16)) u_dut_a (
        .i_clock (clk),
        .i_reset (rst_n),
        .sb      (ifa)
    );

    hazard_scoreboard #(.NB_CNT(3)) u_dut_b (
        .i_clock (clk),
        .i_reset (rst_n),
        .sb      (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: instructions by age since leaving ID (0 = now in EX).
    bit m_v[N], m_we[N], m_ld[N];
    int m_rd[N];
    int m_cnt_a = 0;
    int m_cnt_b = 0;

    function automatic bit m_match(int a, int x);
        return m_v[a] && m_we[a] && (m_rd[a] == x) && (x != 0);
    endfunction

    // Age at which the result can be consumed; ID consumers need one more.
    function automatic int m_avail(int a);
        return (m_ld[a] ? LR : AR) + (jb ? 1 : 0);
    endfunction

    function automatic bit m_late(int a, int x);
        return m_match(a, x) && (a < N - 1) && (a < m_avail(a));
    endfunction

    function automatic bit m_hazard();
        bit h = 1'b0;
        if (!idv || flush) return 1'b0;
        for (int a = 0; a < N; a++) begin
            if (urs && m_late(a, int'(rs))) h = 1'b1;
            if (urt && m_late(a, int'(rt))) h = 1'b1;
        end
        return h;
    endfunction

    function automatic int m_fwd(int x);
        for (int a = 0; a < N; a++)
            if (m_match(a, x) && !m_late(a, x)) return a + 1;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < N; a++) begin
                m_v[a] <= 1'b0;
                m_we[a] <= 1'b0;
                m_ld[a] <= 1'b0;
                m_rd[a] <= 0;
            end
            m_cnt_a <= 0;
            m_cnt_b <= 0;
        end else if (valid) begin
            if (m_hazard()) begin
                m_cnt_a <= (m_cnt_a < 65535) ? m_cnt_a + 1 : 65535;
                m_cnt_b <= (m_cnt_b < 7) ? m_cnt_b + 1 : 7;
            end
            for (int a = N - 1; a > 0; a--) begin
                m_v[a] <= m_v[a-1];
                m_we[a] <= m_we[a-1];
                m_ld[a] <= m_ld[a-1];
                m_rd[a] <= m_rd[a-1];
            end
            m_v[0] <= idv && !flush && !m_hazard();
            m_we[0] <= we;
            m_ld[0] <= re;
            m_rd[0] <= int'(rd);
        end
    end

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: compare both DUT copies against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_hazard_a", int'(ifa.o_hazard), int'(m_hazard()));
            chk("cyc_hazard_b", int'(ifb.o_hazard), int'(m_hazard()));
            chk("cyc_cnt_a", int'(ifa.o_stall_cycles), m_cnt_a);
            chk("cyc_cnt_b", int'(ifb.o_stall_cycles), m_cnt_b);
            if (!m_hazard() && idv && !flush) begin
                if (urs) chk("cyc_fwd_rs", int'(ifa.o_fwd_rs), m_fwd(int'(rs)));
                if (urt) chk("cyc_fwd_rt", int'(ifa.o_fwd_rt), m_fwd(int'(rt)));
            end
        end
    end

    task automatic set_in(bit v_id, int a_rs, int a_rt, bit u_rs, bit u_rt,
                          bit br, int a_rd, bit w, bit ld);
        idv = v_id;
        rs = 5'(a_rs);
        rt = 5'(a_rt);
        urs = u_rs;
        urt = u_rt;
        jb = br;
        rd = 5'(a_rd);
        we = w;
        re = ld;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b1;
        flush = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("reset_hazard", int'(ifa.o_hazard), 0);
        chk("reset_cnt", int'(ifa.o_stall_cycles), 0);
        #9 rst_n = 1'b1;
        nxt();

        // load r5, then add reading r5 on both operands
        set_in(1, 0, 0, 0, 0, 0, 5, 1, 1);
        nxt();
        set_in(1, 5, 5, 1, 1, 0, 0, 0, 0);
        #1 chk("ldu_stall", int'(ifa.o_hazard), 1);
        nxt();
        #1 chk("ldu_release", int'(ifa.o_hazard), 0);
        chk("ldu_fwd_rs", int'(ifa.o_fwd_rs), 2);
        chk("ldu_fwd_rt", int'(ifa.o_fwd_rt), 2);
        chk("ldu_cnt", int'(ifa.o_stall_cycles), 1);
        nxt();

        // ALU r3, then beq on rt=3
        set_in(1, 0, 0, 0, 0, 0, 3, 1, 0);
        nxt();
        set_in(1, 0, 3, 0, 1, 1, 0, 0, 0);
        #1 chk("alu_br_stall", int'(ifa.o_hazard), 1);
        nxt();
        #1 chk("alu_br_release", int'(ifa.o_hazard), 0);
        chk("alu_br_fwd", int'(ifa.o_fwd_rt), 2);
        nxt();

        // load r3, then beq on rt=3: two stalls
        set_in(1, 0, 0, 0, 0, 0, 3, 1, 1);
        nxt();
        set_in(1, 0, 3, 0, 1, 1, 0, 0, 0);
        #1 chk("ld_br_stall1", int'(ifa.o_hazard), 1);
        nxt();
        #1 chk("ld_br_stall2", int'(ifa.o_hazard), 1);
        nxt();
        #1 chk("ld_br_release", int'(ifa.o_hazard), 0);
        chk("ld_br_fwd", int'(ifa.o_fwd_rt), 3);
        chk("ld_br_cnt", int'(ifa.o_stall_cycles), 4);
        nxt();

        // writes to r0 are ignored
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0);
        nxt();
        set_in(1, 0, 0, 1, 0, 0, 0, 0, 0);
        #1 chk("r0_hazard", int'(ifa.o_hazard), 0);
        chk("r0_fwd", int'(ifa.o_fwd_rs), 0);
        nxt();

        // r7 written twice, youngest forwards
        set_in(1, 0, 0, 0, 0, 0, 7, 1, 0);
        nxt();
        nxt();
        set_in(1, 7, 0, 1, 0, 0, 0, 0, 0);
        #1 chk("dup_hazard", int'(ifa.o_hazard), 0);
        chk("dup_fwd", int'(ifa.o_fwd_rs), 1);
        set_in(1, 7, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("nouse_hazard", int'(ifa.o_hazard), 0);
        nxt();

        // load r4 with dependent flushed, then freeze with branch waiting
        set_in(1, 0, 0, 0, 0, 0, 4, 1, 1);
        nxt();
        set_in(1, 4, 0, 1, 0, 0, 0, 0, 0);
        flush = 1'b1;
        #1 chk("flush_hazard", int'(ifa.o_hazard), 0);
        nxt();
        flush = 1'b0;
        valid = 1'b0;
        set_in(1, 4, 0, 1, 0, 1, 0, 0, 0);
        #1 chk("frz_hazard", int'(ifa.o_hazard), 1);
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("frz_hold", int'(ifa.o_hazard), 1);
            chk("frz_cnt", int'(ifa.o_stall_cycles), 4);
        end
        valid = 1'b1;
        nxt();
        #1 chk("thaw_release", int'(ifa.o_hazard), 0);
        chk("thaw_fwd", int'(ifa.o_fwd_rs), 3);
        chk("thaw_cnt", int'(ifa.o_stall_cycles), 5);
        nxt();

        // asynchronous reset during a load-use stall
        set_in(1, 0, 0, 0, 0, 0, 9, 1, 1);
        nxt();
        set_in(1, 9, 0, 1, 0, 0, 0, 0, 0);
        #1 chk("pre_rst_hazard", int'(ifa.o_hazard), 1);
        rst_n = 1'b0;
        #1 chk("rst_hazard", int'(ifa.o_hazard), 0);
        chk("rst_cnt_a", int'(ifa.o_stall_cycles), 0);
        chk("rst_cnt_b", int'(ifb.o_stall_cycles), 0);
        #1 rst_n = 1'b1;
        nxt();

        // repeated load/branch pairs: two stalls each
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, 0, 0, 0, 6, 1, 1);
            nxt();
            set_in(1, 6, 0, 1, 0, 1, 0, 0, 0);
            nxt();
            nxt();
        end
        chk("sat_cnt_a", int'(ifa.o_stall_cycles), 8);
        chk("sat_cnt_b", int'(ifb.o_stall_cycles), 7);
        set_in(1, 0, 0, 0, 0, 0, 6, 1, 1);
        nxt();
        set_in(1, 6, 0, 1, 0, 1, 0, 0, 0);
        nxt();
        nxt();
        chk("sat_hold_a", int'(ifa.o_stall_cycles), 10);
        chk("sat_hold_b", int'(ifb.o_stall_cycles), 7);

        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        nxt();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
